uart_string_recv: RTL and testbench

Receive-side string assembler for the UART path. Collects a fixed number of bytes delivered one at a time by the UART byte receiver into a single `byte_num*8`-bit word. It presents that word with a one-cycle valid pulse once all bytes have arrived. Byte order is the inverse of the string sender: the first byte received lands in the most-significant byte. An optional inter-byte timeout discards incomplete strings.

---
 rtl/uart_string_recv.sv | 65 ++++++
 tb/tb_uart_string_recv.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_string_recv.sv
// uart_string_recv: assembles byte_num UART bytes (first byte in the MSB) into one word.
// Define UART_STRING_RECV_TIMEOUT_EN to build the inter-byte timeout that discards partial strings.
module uart_string_recv #(
  parameter int byte_num       = 1,
  parameter int timeout_cycles = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    uart_data,
  input  logic                          uart_rx_done,
  output logic [byte_num*8-1:0]         string_out,
  output logic                          string_valid,
  output logic                          idle_flag,
  output logic [$clog2(byte_num+1)-1:0] byte_cnt,
  output logic                          timeout_err
);
  localparam int W  = byte_num * 8;
  localparam int CW = $clog2(byte_num + 1);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state, state_d;
  logic rx_d, capture, done, expire;
  logic [W-1:0] shift, nxt;
  assign capture   = uart_rx_done && !rx_d;
  assign done      = capture && byte_cnt == CW'(byte_num - 1);
  assign nxt       = state == IDLE ? W'(uart_data) : (shift << 8) | W'(uart_data);
  assign idle_flag = state == IDLE;
`ifdef UART_STRING_RECV_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles + 1);
  logic [TW-1:0] tcnt;
  // a capture on the expiry edge wins, so expiry is masked by capture
  assign expire = state == RECV && !capture && tcnt == TW'(timeout_cycles - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) tcnt <= '0;
    else tcnt <= (capture || expire || state == IDLE) ? '0 : tcnt + TW'(1);
`else
  // timeout_cycles is meaningless without the counter; expire is constant 0
  assign expire = timeout_cycles < 0;
`endif
  always_comb begin
    state_d = capture ? (done ? IDLE : RECV) : (expire ? IDLE : state);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rx_d         <= 1'b0;
      shift        <= '0;
      string_out   <= '0;
      string_valid <= 1'b0;
      timeout_err  <= 1'b0;
      byte_cnt     <= '0;
    end else begin
      state        <= state_d;
      rx_d         <= uart_rx_done;
      string_valid <= done;
      timeout_err  <= expire;
      if (capture) begin
        shift    <= nxt;
        byte_cnt <= done ? '0 : byte_cnt + CW'(1);
      end else if (expire) begin
        byte_cnt <= '0;
      end
      if (done) string_out <= nxt;
    end
  end
endmodule

// File: tb/tb_uart_string_recv.sv
// tb_uart_string_recv: checks 4-byte and 1-byte instances against a queue-based string model.
module tb_uart_string_recv;
  localparam int TO = 100;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] data = 8'h00;
  logic done = 1'b0;
  logic [31:0] out4;
  logic v4, idle4, terr4;
  logic [2:0] cnt4;
  logic [7:0] out1;
  logic v1, idle1, terr1;
  logic [0:0] cnt1;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  bit prev;
  int edge_n = 0, last_cap = 0;
  logic [31:0] m_out;
  logic [7:0] m_out1;
  bit m_v, m_terr, m_v1;

  uart_string_recv #(.byte_num(4), .timeout_cycles(TO)) dut4 (
    .clk(clk), .rst(rst), .uart_data(data), .uart_rx_done(done),
    .string_out(out4), .string_valid(v4), .idle_flag(idle4),
    .byte_cnt(cnt4), .timeout_err(terr4));
  uart_string_recv #(.byte_num(1), .timeout_cycles(TO)) dut1 (
    .clk(clk), .rst(rst), .uart_data(data), .uart_rx_done(done),
    .string_out(out1), .string_valid(v1), .idle_flag(idle1),
    .byte_cnt(cnt1), .timeout_err(terr1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    prev = 1'b0; m_out = '0; m_v = 0; m_terr = 0; m_out1 = '0; m_v1 = 0;
  endtask

  task automatic model_edge(input logic d, input logic [7:0] b);
    bit cap;
    edge_n++;
    cap = d && !prev;
    prev = d;
    m_v = 0; m_terr = 0; m_v1 = 0;
    if (cap) begin
      q.push_back(b);
      last_cap = edge_n;
      m_out1 = b; m_v1 = 1;
      if (q.size() == 4) begin
        m_out = {q[0], q[1], q[2], q[3]};
        m_v = 1;
        q.delete();
      end
    end
`ifdef UART_STRING_RECV_TIMEOUT_EN
    else if (q.size() > 0 && edge_n - last_cap == TO) begin
      q.delete();
      m_terr = 1;
    end
`endif
  endtask

  task automatic cmp_all();
    chk("out4", out4, m_out);
    chk("valid4", {31'b0, v4}, {31'b0, m_v});
    chk("cnt4", {29'b0, cnt4}, q.size());
    chk("idle4", {31'b0, idle4}, {31'b0, q.size() == 0});
    chk("terr4", {31'b0, terr4}, {31'b0, m_terr});
    chk("out1", {24'b0, out1}, {24'b0, m_out1});
    chk("valid1", {31'b0, v1}, {31'b0, m_v1});
    chk("idle1", {31'b0, idle1}, 32'd1);
    chk("cnt1", {31'b0, cnt1}, 32'd0);
    chk("terr1", {31'b0, terr1}, 32'd0);
  endtask

  task automatic step(input logic d, input logic [7:0] b);
    done = d;
    data = b;
    @(posedge clk);
    model_edge(d, b);
    #1 cmp_all();
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(1'b1, b);
    repeat (gap) step(1'b0, 8'($urandom));
  endtask

  task automatic reset_check(input string nm);
    chk({nm, "_out4"}, out4, 32'h0);
    chk({nm, "_valid4"}, {31'b0, v4}, 32'd0);
    chk({nm, "_idle4"}, {31'b0, idle4}, 32'd1);
    chk({nm, "_cnt4"}, {29'b0, cnt4}, 32'd0);
    chk({nm, "_terr4"}, {31'b0, terr4}, 32'd0);
    chk({nm, "_out1"}, {24'b0, out1}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  data;
    int          gap;
    logic [2:0]  cnt;
    logic        v;
    logic [31:0] out;
    logic        idle;
  } vec_t;
  vec_t tbl[4];

  initial begin
    int pulses, t_edge;
    tbl[0] = '{8'h41, 20, 3'd1, 1'b0, 32'h0, 1'b0};
    tbl[1] = '{8'h42, 20, 3'd2, 1'b0, 32'h0, 1'b0};
    tbl[2] = '{8'h43, 20, 3'd3, 1'b0, 32'h0, 1'b0};
    tbl[3] = '{8'h44, 20, 3'd0, 1'b1, 32'h41424344, 1'b1};
    #2 rst = 1'b1;
    #1 model_reset();
    reset_check("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, tbl[i].data);
      chk("tbl_cnt", {29'b0, cnt4}, {29'b0, tbl[i].cnt});
      chk("tbl_valid", {31'b0, v4}, {31'b0, tbl[i].v});
      chk("tbl_out", out4, tbl[i].out);
      chk("tbl_idle", {31'b0, idle4}, {31'b0, tbl[i].idle});
      repeat (tbl[i].gap) step(1'b0, 8'($urandom));
    end
`ifdef UART_STRING_RECV_TIMEOUT_EN
    send(8'h11, 3);
    step(1'b1, 8'h22);
    t_edge = -1;
    for (int i = 1; i <= 110; i++) begin
      step(1'b0, 8'($urandom));
      if (terr4 && t_edge < 0) t_edge = i;
    end
    chk("terr_edge", t_edge, 32'd100);
    chk("terr_out_kept", out4, 32'h41424344);
`endif
    send(8'hA1, 4); send(8'hA2, 4); send(8'hA3, 4); send(8'hA4, 4);
    chk("a_str", out4, 32'hA1A2A3A4);
    send(8'h11, 3);
    step(1'b1, 8'h22);
    repeat (99) step(1'b0, 8'($urandom));
    step(1'b1, 8'h33);
    chk("collide_terr", {31'b0, terr4}, 32'd0);
    chk("collide_cnt", {29'b0, cnt4}, 32'd3);
    repeat (3) step(1'b0, 8'($urandom));
    send(8'h44, 3);
    chk("collide_str", out4, 32'h11223344);
    pulses = 0;
    for (int b = 1; b <= 4; b++) begin
      step(1'b1, 8'(b));
      if (v4) pulses++;
      repeat (4) begin
        step(1'b1, 8'($urandom));
        if (v4) pulses++;
      end
      repeat (3) begin
        step(1'b0, 8'($urandom));
        if (v4) pulses++;
      end
    end
    chk("hold_pulses", pulses, 32'd1);
    chk("hold_str", out4, 32'h01020304);
    send(8'h99, 3); send(8'h98, 3);
    rst = 1'b1;
    #1 model_reset();
    reset_check("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(8'hDE, 2); send(8'hAD, 2); send(8'hBE, 2); send(8'hEF, 2);
    chk("dead_str", out4, 32'hDEADBEEF);
    send(8'h5A, 0);
    chk("one_str", {24'b0, out1}, 32'h5A);
    chk("one_valid", {31'b0, v1}, 32'd1);
    step(1'b0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 100 < 4) repeat ($urandom_range(90, 130)) step(1'b0, 8'($urandom));
      else step(1'($urandom), 8'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
